// File: rtl/keypad_scan_onehot_if.sv
// Keypad-side bundle of keypad_scan_onehot: row sense, column drive and the committed
// one-hot code with its press/release strobes.
interface keypad_scan_onehot_if;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] onehot;
    logic        key_press;
    logic        key_release;

    modport master (
        output row_in,
        input  col_out,
        input  onehot,
        input  key_press,
        input  key_release
    );

    modport slave (
        input  row_in,
        output col_out,
        output onehot,
        output key_press,
        output key_release
    );
endinterface

// File: rtl/keypad_scan_onehot.sv
// 4x4 matrix keypad scanner with frame debounce and one-hot key code output.
// Optional macro KEYPAD_GHOST_REJECT_EN: multi-key frames reduce to "no key" instead of lowest bit.
module keypad_scan_onehot #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int SCAN_DIV       = 50_000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic               clk,
    input  logic               RSTn,
    keypad_scan_onehot_if.slave kp
);
    localparam int SLOT_W  = $clog2(SCAN_DIV);
    localparam int MATCH_W = $clog2(DEBOUNCE_SCANS);
    localparam logic [SLOT_W-1:0]  SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(DEBOUNCE_SCANS - 1);

    if ((CLK_HZ < 1) || (SCAN_DIV < 4) || (DEBOUNCE_SCANS < 2)) begin : g_bad_cfg
        $error("keypad_scan_onehot: invalid parameter set");
    end

    logic [3:0]         row_meta_r;
    logic [3:0]         row_sync_r;
    logic [3:0]         rows_s;
    logic [SLOT_W-1:0]  slot_cnt_r;
    logic [1:0]         col_idx_r;
    logic [1:0]         col_next_s;
    logic [3:0]         col_out_r;
    logic [15:0]        raw_frame_r;
    logic [15:0]        frame_next_s;
    logic [15:0]        prev_frame_r;
    logic [MATCH_W-1:0] match_cnt_r;
    logic               commit_pend_r;
    logic [15:0]        reduced_s;
    logic [15:0]        onehot_r;
    logic               press_r;
    logic               release_r;
    logic               slot_last_s;
    logic               frame_done_s;
    logic               commit_s;

    function automatic logic [15:0] reduce_frame(input logic [15:0] f);
`ifdef KEYPAD_GHOST_REJECT_EN
        if ((f & (f - 16'd1)) != 16'd0) begin
            return 16'h0000;
        end else begin
            return f;
        end
`else
        return f & (~f + 16'd1);
`endif
    endfunction

    // Scan timing, frame assembly and commit decision.
    always_comb begin
        rows_s       = ~row_sync_r;
        slot_last_s  = (slot_cnt_r == SLOT_LAST);
        frame_done_s = slot_last_s && (col_idx_r == 2'd3);
        col_next_s   = col_idx_r + 2'd1;
        frame_next_s = raw_frame_r;
        for (int r = 0; r < 4; r++) begin
            frame_next_s[{2'(r), col_idx_r}] = rows_s[r];
        end
        reduced_s = reduce_frame(prev_frame_r);
        commit_s  = commit_pend_r && (match_cnt_r == MATCH_MAX) && (reduced_s != onehot_r);
    end

    // Two-flop synchronizer on the asynchronous row pins.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            row_meta_r <= 4'hF;
            row_sync_r <= 4'hF;
        end else begin
            row_meta_r <= kp.row_in;
            row_sync_r <= row_meta_r;
        end
    end

    // Column slot counter and registered column drive.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            slot_cnt_r <= '0;
            col_idx_r  <= 2'd0;
            col_out_r  <= 4'b1110;
        end else if (slot_last_s) begin
            slot_cnt_r <= '0;
            col_idx_r  <= col_next_s;
            col_out_r  <= ~(4'b0001 << col_next_s);
        end else begin
            slot_cnt_r <= slot_cnt_r + SLOT_W'(1);
        end
    end

    // Raw frame capture at the end of each column slot.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            raw_frame_r <= 16'h0000;
        end else if (slot_last_s) begin
            raw_frame_r <= frame_next_s;
        end else begin
            raw_frame_r <= raw_frame_r;
        end
    end

    // Frame-to-frame debounce; match count saturates so a held key keeps qualifying.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            prev_frame_r  <= 16'h0000;
            match_cnt_r   <= '0;
            commit_pend_r <= 1'b0;
        end else begin
            commit_pend_r <= frame_done_s;
            if (frame_done_s) begin
                prev_frame_r <= frame_next_s;
                if (frame_next_s != prev_frame_r) begin
                    match_cnt_r <= '0;
                end else if (match_cnt_r != MATCH_MAX) begin
                    match_cnt_r <= match_cnt_r + MATCH_W'(1);
                end else begin
                    match_cnt_r <= match_cnt_r;
                end
            end else begin
                prev_frame_r <= prev_frame_r;
                match_cnt_r  <= match_cnt_r;
            end
        end
    end

    // Committed code and single-cycle strobes, updated together.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            onehot_r  <= 16'h0000;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else if (commit_s) begin
            onehot_r  <= reduced_s;
            press_r   <= (reduced_s != 16'h0000);
            release_r <= (reduced_s == 16'h0000);
        end else begin
            onehot_r  <= onehot_r;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end
    end

    assign kp.col_out     = col_out_r;
    assign kp.onehot      = onehot_r;
    assign kp.key_press   = press_r;
    assign kp.key_release = release_r;
endmodule

// File: tb/tb_keypad_scan_onehot.sv
// Directed bench for keypad_scan_onehot (SCAN_DIV=8, DEBOUNCE_SCANS=3) with a keypad matrix model.
module tb_keypad_scan_onehot;
    logic        clk = 1'b0;
    logic        RSTn = 1'b0;
    logic [15:0] keys = 16'h0000;
    logic [3:0]  row_s;
    int n_checks = 0;
    int n_pass   = 0;
    int press_cnt = 0;
    int release_cnt = 0;
    int both_cnt = 0;

    keypad_scan_onehot_if kp_if ();

    keypad_scan_onehot #(
        .CLK_HZ(50_000_000),
        .SCAN_DIV(8),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .clk (clk),
        .RSTn(RSTn),
        .kp  (kp_if)
    );

    always #5 clk = ~clk;

    // Pressed key at row r / column c pulls row r low while column c is driven low.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_s[r] = ~|(keys[4*r +: 4] & ~kp_if.col_out);
        end
    end
    assign kp_if.row_in = row_s;

    // Strobe counters sampled on the falling edge.
    always @(negedge clk) begin
        if (kp_if.key_press)   press_cnt   <= press_cnt + 1;
        if (kp_if.key_release) release_cnt <= release_cnt + 1;
        if (kp_if.key_press && kp_if.key_release) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [15:0] k);
        RSTn = 1'b0;
        keys = k;
        step(2);
        RSTn = 1'b1;
    endtask

    initial begin
        int p0, r0, lat;
        logic [15:0] exp_ghost;
        int exp_gp;

        // Reset and idle scanning
        step(3);
        check("rst_col", {28'd0, kp_if.col_out}, 32'h0000000E);
        check("rst_onehot", {16'd0, kp_if.onehot}, 32'h0);
        check("rst_strobes", {30'd0, kp_if.key_press, kp_if.key_release}, 32'h0);
        RSTn = 1'b1;
        check("col0_start", {28'd0, kp_if.col_out}, 32'hE);
        step(7);
        check("col0_end", {28'd0, kp_if.col_out}, 32'hE);
        step(1);
        check("col1", {28'd0, kp_if.col_out}, 32'hD);
        step(8);
        check("col2", {28'd0, kp_if.col_out}, 32'hB);
        step(8);
        check("col3", {28'd0, kp_if.col_out}, 32'h7);
        step(8);
        check("col_wrap", {28'd0, kp_if.col_out}, 32'hE);
        p0 = press_cnt; r0 = release_cnt;
        step(20 * 32);
        check("idle_press", press_cnt - p0, 0);
        check("idle_release", release_cnt - r0, 0);
        check("idle_onehot", {16'd0, kp_if.onehot}, 32'h0);

        // Press row1/col2 from reset: commit one cycle after edge 96
        p0 = press_cnt; r0 = release_cnt;
        do_reset(16'h0040);
        step(96);
        check("press_early", {16'd0, kp_if.onehot}, 32'h0);
        step(1);
        check("press_onehot", {16'd0, kp_if.onehot}, 32'h40);
        check("press_strobe", {31'd0, kp_if.key_press}, 32'h1);
        step(1);
        check("press_strobe_off", {31'd0, kp_if.key_press}, 32'h0);
        step(320);
        check("hold_press_cnt", press_cnt - p0, 1);
        check("hold_release_cnt", release_cnt - r0, 0);
        keys = 16'h0000;
        lat = 0;
        while (kp_if.onehot != 16'h0000 && lat < 200) begin
            step(1);
            lat++;
        end
        check("release_latency_ok", {31'd0, (lat <= 131)}, 32'h1);
        check("release_onehot", {16'd0, kp_if.onehot}, 32'h0);
        check("release_strobe", {31'd0, kp_if.key_release}, 32'h1);
        step(1);
        check("release_cnt", release_cnt - r0, 1);
        check("release_press_cnt", press_cnt - p0, 1);

        // Bounce on row0/col0 then hold
        p0 = press_cnt; r0 = release_cnt;
        do_reset(16'h0000);
        for (int f = 0; f < 4; f++) begin
            keys = (f % 2 == 0) ? 16'h0001 : 16'h0000;
            step(32);
        end
        keys = 16'h0001;
        step(32 * 6);
        check("bounce_onehot", {16'd0, kp_if.onehot}, 32'h1);
        check("bounce_press_cnt", press_cnt - p0, 1);
        check("bounce_release_cnt", release_cnt - r0, 0);

        // Ghost pair row0/col0 + row3/col3
`ifdef KEYPAD_GHOST_REJECT_EN
        exp_ghost = 16'h0000; exp_gp = 0;
`else
        exp_ghost = 16'h0001; exp_gp = 1;
`endif
        p0 = press_cnt; r0 = release_cnt;
        do_reset(16'h8001);
        step(32 * 8);
        check("ghost_onehot", {16'd0, kp_if.onehot}, {16'd0, exp_ghost});
        check("ghost_press_cnt", press_cnt - p0, exp_gp);
        check("ghost_release_cnt", release_cnt - r0, 0);

        // Direct key change 0x0200 -> 0x1000
        p0 = press_cnt; r0 = release_cnt;
        do_reset(16'h0200);
        step(32 * 5);
        check("chg_first", {16'd0, kp_if.onehot}, 32'h200);
        keys = 16'h1000;
        step(32 * 6);
        check("chg_second", {16'd0, kp_if.onehot}, 32'h1000);
        check("chg_press_cnt", press_cnt - p0, 2);
        check("chg_release_cnt", release_cnt - r0, 0);

        // Reset while a key is committed
        do_reset(16'h0040);
        step(130);
        check("mid_committed", {16'd0, kp_if.onehot}, 32'h40);
        p0 = press_cnt; r0 = release_cnt;
        RSTn = 1'b0;
        #1;
        check("mid_rst_onehot", {16'd0, kp_if.onehot}, 32'h0);
        check("mid_rst_col", {28'd0, kp_if.col_out}, 32'hE);
        check("mid_rst_strobes", {30'd0, kp_if.key_press, kp_if.key_release}, 32'h0);
        step(3);
        RSTn = 1'b1;
        step(96);
        check("mid_recommit_early", {16'd0, kp_if.onehot}, 32'h0);
        step(1);
        check("mid_recommit", {16'd0, kp_if.onehot}, 32'h40);
        step(1);
        check("mid_press_cnt", press_cnt - p0, 1);
        check("mid_release_cnt", release_cnt - r0, 0);

        check("never_both_strobes", both_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
